rheed_pixel_packer: RTL

RHEED_PIXEL_PACKER -- requirements
Module: rheed_pixel_packer

---
 rtl/rheed_pkg.sv | 27 ++
 rtl/rheed_pixel_packer.sv | 109 ++++++++++
 2 files changed

// File: rtl/rheed_pkg.sv
// Shared constants and the packer state type used by the RHEED pixel path.
// Contents: AXI word geometry, lane counter width, packer FSM enum,
// and a helper that builds a byte-lane keep mask from the last used lane.
package rheed_pkg;

    localparam int AXI_DATA_W     = 256;
    localparam int PIX_W          = 8;
    localparam int BYTES_PER_WORD = 32;
    localparam int LANE_W         = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_DONE = 2'd2
    } pack_state_t;

    // Lanes 0..last_lane are valid; lane 31 yields a full mask.
    function automatic logic [BYTES_PER_WORD-1:0] keep_mask(input logic [LANE_W-1:0] last_lane);
        logic [BYTES_PER_WORD-1:0] m;
        m = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            m[i] = (i <= int'(last_lane));
        end
        return m;
    endfunction

endpackage

// File: rtl/rheed_pixel_packer.sv
// Packs a cropped Mono8 frame (OUT_ROWS x OUT_COLS, raster order) into
// 256-bit AXI-Stream words, 32 pixels per word, pixel k in byte lane k.
// Ports: clk/reset (sync, active-high); ap_start/ap_idle/ap_done control;
// s_axis_* 8-bit pixel input; m_axis_* 256-bit output with tkeep/tlast.
// Latency: a word is valid one cycle after its closing pixel handshake.
// Backpressure: pixel input stalls while the output word is held unaccepted.
module rheed_pixel_packer
    import rheed_pkg::*;
#(
    parameter int OUT_ROWS = 20,
    parameter int OUT_COLS = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ap_start,
    output logic                      ap_idle,
    output logic                      ap_done,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [PIX_W-1:0]          s_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [AXI_DATA_W-1:0]     m_axis_tdata,
    output logic [BYTES_PER_WORD-1:0] m_axis_tkeep,
    output logic                      m_axis_tlast
);

    localparam int N     = OUT_ROWS * OUT_COLS;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N);

    pack_state_t           state;
    logic [CNT_W-1:0]      pix_cnt;
    logic [LANE_W-1:0]     lane;
    logic [AXI_DATA_W-1:0] asm_q;
    logic [AXI_DATA_W-1:0] asm_next;
    logic                  pix_acc;
    logic                  last_pix;
    logic                  word_end;
    logic                  out_hs;

    assign ap_idle = (state == ST_IDLE);
    assign ap_done = (state == ST_DONE);

    // Input is refused while a completed word waits downstream, so the
    // output register can never be overwritten before it is taken.
    assign s_axis_tready = (state == ST_PACK) && (pix_cnt < N_CNT)
                           && !(m_axis_tvalid && !m_axis_tready);

    assign pix_acc  = s_axis_tvalid && s_axis_tready;
    assign last_pix = (pix_cnt == LAST_IDX);
    assign word_end = (lane == 5'd31) || last_pix;
    assign out_hs   = m_axis_tvalid && m_axis_tready;

    // Assembly word with the incoming pixel dropped into the current lane.
    always_comb begin
        asm_next = asm_q;
        asm_next[{lane, 3'b000} +: PIX_W] = s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            pix_cnt       <= '0;
            lane          <= '0;
            asm_q         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ap_start) begin
                        state   <= ST_PACK;
                        pix_cnt <= '0;
                        lane    <= '0;
                        asm_q   <= '0;
                    end
                end
                ST_PACK: begin
                    if (out_hs && m_axis_tlast) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            if (pix_acc) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
                lane    <= lane + LANE_W'(1);
                // Clearing on word close keeps unused bytes of a short final word at zero.
                asm_q   <= word_end ? '0 : asm_next;
            end

            if (pix_acc && word_end) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= asm_next;
                m_axis_tkeep  <= keep_mask(lane);
                m_axis_tlast  <= last_pix;
            end else if (out_hs) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
